// File: rtl/stream_downsize.sv
// stream_downsize: splits wide beats of T_DATA_RATIO lanes into narrow words,
// lane 0 first, skipping lanes whose keep bit is clear.
// Ports: clk, rst (async, active-high)
//   slave:  s_data_i, s_keep_i, s_last_i, s_valid_i, s_ready_o
//   master: m_data_o, m_last_o, m_valid_o, m_ready_i
// Option: define STREAM_DOWNSIZE_BACK2BACK_EN to accept a new beat on
// the same cycle as the final narrow word leaves.
module stream_downsize #(
  parameter int T_DATA_WIDTH = 32,
  parameter int T_DATA_RATIO = 4
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [T_DATA_RATIO-1:0][T_DATA_WIDTH-1:0] s_data_i,
  input  logic [T_DATA_RATIO-1:0]                  s_keep_i,
  input  logic                                     s_last_i,
  input  logic                                     s_valid_i,
  output logic                                     s_ready_o,
  output logic [T_DATA_WIDTH-1:0]                  m_data_o,
  output logic                                     m_last_o,
  output logic                                     m_valid_o,
  input  logic                                     m_ready_i
);

  localparam int IW = $clog2(T_DATA_RATIO);

  typedef enum logic {IDLE, SEND} state_t;

  state_t state_q, state_d;

  logic [T_DATA_RATIO-1:0][T_DATA_WIDTH-1:0] beat_q;
  logic [T_DATA_RATIO-1:0] rem_q;
  logic                    last_q;

  logic [IW-1:0]           lane;
  logic [T_DATA_RATIO-1:0] lane_oh;
  logic                    final_lane;
  logic                    s_xfer;
  logic                    m_xfer;

  assign s_xfer = s_valid_i & s_ready_o;
  assign m_xfer = m_valid_o & m_ready_i;

  // lowest pending lane, both as index and one-hot
  always_comb begin
    lane = '0;
    for (int i = T_DATA_RATIO - 1; i >= 0; i--) begin
      if (rem_q[i]) lane = IW'(i);
    end
  end

  assign lane_oh    = rem_q & (~rem_q + T_DATA_RATIO'(1));
  assign final_lane = (rem_q & ~lane_oh) == '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (s_xfer && (|s_keep_i)) state_d = SEND;
      end
      SEND: begin
        if (m_xfer && final_lane)
          state_d = (s_xfer && (|s_keep_i)) ? SEND : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef STREAM_DOWNSIZE_BACK2BACK_EN
  always_comb begin
    s_ready_o = (state_q == IDLE) |
                (m_valid_o & m_ready_i & final_lane);
  end
`else
  // one idle cycle after a beat drains; ready comes from state only
  logic bubble_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bubble_q <= 1'b0;
    else     bubble_q <= m_xfer & final_lane;
  end

  always_comb begin
    s_ready_o = (state_q == IDLE) & ~bubble_q;
  end
`endif

  always_comb begin
    m_valid_o = (state_q == SEND);
    m_last_o  = m_valid_o & last_q & final_lane;
    m_data_o  = m_valid_o ? beat_q[lane] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q <= '0;
      rem_q  <= '0;
      last_q <= 1'b0;
    end else if (s_xfer) begin
      beat_q <= s_data_i;
      rem_q  <= s_keep_i;
      last_q <= s_last_i;
    end else if (m_xfer) begin
      rem_q  <= rem_q & ~lane_oh;
    end
  end

endmodule

// File: doc/stream_downsize.md
STREAM_DOWNSIZE -- requirements
Module: stream_downsize

Interface
REQ-001 SHALL have parameter T_DATA_WIDTH, default 32, width in bits of one narrow word.
REQ-002 SHALL have parameter T_DATA_RATIO, default 4, number of narrow lanes per wide beat; legal values are 2 to 16.
REQ-003 SHALL have clk  input  1  single clock; all state changes occur on its rising edge.
REQ-004 SHALL have rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have s_data_i  input  T_DATA_WIDTH x T_DATA_RATIO array  wide slave data; lane 0 is the first in stream order.
REQ-006 SHALL have s_keep_i  input  T_DATA_RATIO  per-lane valid mask for s_data_i.
REQ-007 SHALL have s_last_i  input  1  the wide beat ends a packet.
REQ-008 SHALL have s_valid_i input 1, and s_ready_o output 1, forming the slave handshake.
REQ-009 SHALL have m_data_o  output  T_DATA_WIDTH  narrow master data.
REQ-010 SHALL have m_last_o  output  1  the narrow word ends a packet.
REQ-011 SHALL have m_valid_o output 1, and m_ready_i input 1, forming the master handshake.

Function
REQ-012 A transfer SHALL occur on a rising edge where valid and ready are both 1; nothing else consumes or produces data.
REQ-013 The FSM SHALL have two states: IDLE (no beat held) and SEND (beat held, kept lanes pending).
REQ-014 In IDLE, s_ready_o SHALL be 1 and m_valid_o SHALL be 0.
REQ-015 On a slave transfer, the block SHALL register s_data_i, s_keep_i and s_last_i into a buffer and a remaining-mask register.
REQ-016 On a slave transfer with s_keep_i nonzero, the FSM SHALL go to SEND; m_valid_o SHALL be 1 in the next cycle (1-cycle latency).
REQ-017 In SEND, m_data_o SHALL be the buffered lane at the lowest set bit of the remaining mask; lanes whose keep bit is 0 SHALL be skipped without taking a cycle.
REQ-018 m_data_o, m_valid_o and m_last_o SHALL be stable while m_valid_o=1 and m_ready_i=0.
REQ-019 On each master transfer, the block SHALL clear the emitted lane's bit in the remaining mask.
REQ-020 m_last_o SHALL be 1 only on the highest kept lane of a beat received with s_last_i=1.
REQ-021 On the master transfer of the final kept lane, the FSM SHALL return to IDLE, unless REQ-027 applies.
REQ-022 A slave beat with s_keep_i=0 SHALL be accepted and dropped; the FSM stays in IDLE and nothing is emitted, even when s_last_i=1.
REQ-023 When the buffer is full (SEND), s_ready_o SHALL be 0, except as stated in REQ-027.
REQ-024 m_data_o SHALL be 0 whenever m_valid_o=0.

Reset
REQ-025 While rst=1, the block SHALL be in IDLE with outputs s_ready_o=1, m_valid_o=0, m_last_o=0, m_data_o=0, and with the buffer and remaining mask at 0.
REQ-026 If rst asserts mid-beat, pending lanes SHALL be discarded, and the first beat accepted after reset release SHALL start at its lowest kept lane.

Configuration
REQ-027 With STREAM_DOWNSIZE_BACK2BACK_EN defined:
- s_ready_o = IDLE | (m_valid_o & m_ready_i & final kept lane);
- a simultaneous slave and master transfer loads the new beat and stays in SEND;
- the 4-lane full-keep steady state SHALL be 4 narrow words per 4 cycles.
REQ-028 Without STREAM_DOWNSIZE_BACK2BACK_EN:
- s_ready_o = IDLE only;
- one bubble cycle SHALL occur between consecutive wide beats;
- full-keep steady state SHALL be 4 narrow words per 6 cycles (1 accept cycle, 4 send cycles, 1 bubble).
- s_ready_o SHALL have no combinational path from m_ready_i.

Verification
REQ-029 The bench SHALL cover these scenarios:
- Full beat: ratio 4, data {0,1,2,3}, keep 4'b1111, last=1, m_ready_i=1 -> 0,1,2,3 on 4 consecutive cycles; m_last_o only with 3.
- Sparse keep: keep 4'b1010, data {A,B,C,D}, last=1 -> exactly B then D on 2 cycles; m_last_o with D.
- Backpressure: m_ready_i=0 for 3 cycles mid-beat -> m_data_o held; no word lost or duplicated; s_ready_o=0 throughout.
- Empty beat: keep 0, last=1, then a beat with keep 4'b0001, data 7 -> only 7 emitted; no output for the dropped beat.
- Back-to-back: 3 full beats with m_ready_i=1 -> 12 words in order; 12 cycles with BACK2BACK_EN, 16 without.
- Reset mid-beat: rst pulse after 2 of 4 words -> no further words; next beat {8,9,10,11} is emitted starting at 8.
